codec_cfg_sequencer: RTL and testbench
======================================

Name: codec_cfg_sequencer

Overview:
- Parametrised successor to the fixed WM8731 register loader.
- Walks an external register table of NUM_REGS {sub-address, data} entries and issues one write per entry through the existing I2C master's command handshake.
- Optional codec soft reset first, a programmable settle gap between writes, and bounded retry on NACK.
- Reports clean completion or failure with the index of the failing entry. Sits between the board key/GO logic and the I2C master.

Parameters:
- NUM_REGS, 10, number of table entries written (1..64).
- ADDR_W, 7, register sub-address width.
- DATA_W, 9, register data width; ADDR_W+DATA_W = 16.
- SEND_RESET, 1, 1 = write {7'h0F, 9'h000} before table entry 0.
- RESET_ADDR, 7'h0F, sub-address used for the soft-reset write.
- SETTLE_CYCLES, 16, idle MCLK cycles after every completed transaction (1..65535).
- MAX_RETRIES, 3, re-issues allowed per entry after a NACK (0..15).

Ports:
- MCLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous active-low reset.
- GO  in  1  start request, asynchronous to MCLK, active high.
- TBL_INDEX  out  clog2(NUM_REGS)  table entry currently selected.
- TBL_ENTRY  in  16  {sub-address, data} for TBL_INDEX; combinational, valid one cycle after TBL_INDEX changes.
- CMD_VALID  out  1  write request to the I2C master.
- CMD_READY  in  1  I2C master can accept a command.
- CMD_DATA  out  16  {sub-address, data} to transmit.
- CMD_DONE  in  1  one-cycle pulse, transaction finished.
- CMD_NACK  in  1  qualified by CMD_DONE: 1 = codec did not acknowledge.
- BUSY  out  1  sequence in progress.
- END  out  1  all writes acknowledged; held until the next start or reset.
- ERROR  out  1  retries exhausted; held until the next start or reset.
- ERR_INDEX  out  clog2(NUM_REGS)+1  failing position: 0 = reset write (when SEND_RESET), else table index+SEND_RESET.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; CMD_VALID=0, CMD_DATA=0, TBL_INDEX=0, BUSY=0, END=0, ERROR=0, ERR_INDEX=0; retry and settle counters 0; GO synchroniser cleared.
- GO path: 2-flop synchroniser, then rising-edge detect.
  - An edge in IDLE, DONE or FAIL starts a sequence.
  - An edge in any other state is ignored.
  - A level held high does not restart the sequence.
- Start: clear END/ERROR/ERR_INDEX and the retry count; BUSY=1 on the cycle after the edge is detected. Next state is RST_ISSUE if SEND_RESET, else LOAD with TBL_INDEX=0.
- LOAD: wait one cycle for TBL_ENTRY, latch it into CMD_DATA, go to ISSUE.
- RST_ISSUE: CMD_DATA={RESET_ADDR, 9'h000}, then behaves as ISSUE.
- ISSUE: CMD_VALID=1, CMD_DATA held stable.
  - On the cycle CMD_VALID&CMD_READY, drop CMD_VALID and go to WAIT.
  - CMD_VALID never deasserts before it is accepted.
- WAIT: idle until CMD_DONE.
  - If NACK=0: clear the retry count, go to SETTLE.
  - If NACK=1 and retry count < MAX_RETRIES: increment the count, go to SETTLE, then re-issue the same entry.
  - If NACK=1 and the count equals MAX_RETRIES: go to FAIL.
- SETTLE: count SETTLE_CYCLES cycles with CMD_VALID=0. Then:
  - After a retry, re-issue the same entry (RST_ISSUE or LOAD).
  - After the last table entry (TBL_INDEX=NUM_REGS-1), go to DONE.
  - Otherwise, after the reset write, go to LOAD with TBL_INDEX=0; after a table entry, increment TBL_INDEX and go to LOAD.
- DONE: END=1, BUSY=0, TBL_INDEX=0.
- FAIL: ERROR=1, BUSY=0, ERR_INDEX latched, TBL_INDEX=0. END is never 1.
- Throughput per write: 2 cycles (LOAD, ISSUE) + the handshake wait + the I2C transaction + SETTLE_CYCLES. The first CMD_VALID rises 3 cycles after the synchronised GO edge.
- A CMD_DONE outside WAIT is ignored. A CMD_DONE coincident with acceptance is not possible by the master's contract and is not handled.
- Reset mid-transaction returns to IDLE immediately. Recovery of the I2C master is the master's own reset.
- END and ERROR are mutually exclusive. BUSY=1 implies END=ERROR=0.
- Counters: the settle counter is 16 bits; the retry counter is 4 bits; TBL_INDEX never exceeds NUM_REGS-1.

Test Plan:
- Default params, all ACKs, READY tied high, GO pulse:
  - writes 0x1E00 first, then table entries 0..9 in order, 11 transactions in total;
  - at least 16 idle cycles between each CMD_DONE and the next CMD_VALID;
  - END=1, BUSY=0 after the last settle.
- NACK on table entry 4 twice, then ACK: entry 4's CMD_DATA is issued 3 times, the sequence completes, END=1, ERROR=0.
- NACK on every attempt at entry 7, MAX_RETRIES=3: 4 attempts, then ERROR=1, ERR_INDEX=8, END=0, BUSY=0, no further CMD_VALID.
- SEND_RESET=0, NUM_REGS=1, CMD_READY held low for 20 cycles: CMD_VALID stays high with stable CMD_DATA until READY; exactly one transaction; END=1.
- GO held high for the whole run, plus a second GO edge while BUSY: exactly one sequence. A new GO edge after END restarts and clears END on the next cycle.
- RESET asserted during WAIT of entry 5: all outputs return to reset values asynchronously. After release with GO low, the block stays IDLE with no CMD_VALID.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: walks a {sub-address, data} table and issues one I2C
// write per entry, with optional soft reset first, a settle gap and bounded NACK retry.
module codec_cfg_sequencer #(
    parameter int                NUM_REGS      = 10,
    parameter int                ADDR_W        = 7,
    parameter int                DATA_W        = 9,
    parameter bit                SEND_RESET    = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_ADDR    = 7'h0F,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                MAX_RETRIES   = 3,
    localparam int               IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int               ERR_W         = IDX_W + 1,
    localparam int               CMD_W         = ADDR_W + DATA_W
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             GO,
    output logic [IDX_W-1:0] TBL_INDEX,
    input  logic [CMD_W-1:0] TBL_ENTRY,
    output logic             CMD_VALID,
    input  logic             CMD_READY,
    output logic [CMD_W-1:0] CMD_DATA,
    input  logic             CMD_DONE,
    input  logic             CMD_NACK,
    output logic             BUSY,
    output logic             END,
    output logic             ERROR,
    output logic [ERR_W-1:0] ERR_INDEX
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ISSUE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_SETTLE,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);
    localparam logic [ERR_W-1:0] ERR_OFS     = ERR_W'(SEND_RESET);

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_go_sync;
    logic               r_go_prev;
    logic [IDX_W-1:0]   r_tbl_index;
    logic [CMD_W-1:0]   r_cmd_data;
    logic [3:0]         r_retry_cnt;
    logic [15:0]        r_settle_cnt;
    logic               r_is_reset_wr;
    logic               r_retry_pend;
    logic [ERR_W-1:0]   r_err_index;

    logic               w_go_rise;
    logic               w_settle_done;
    logic               w_retry_ok;
    logic               w_last_entry;

    assign w_go_rise     = r_go_sync[1] & ~r_go_prev;
    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
    assign w_retry_ok    = (r_retry_cnt < RETRY_MAX);
    assign w_last_entry  = !r_is_reset_wr && (r_tbl_index == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next state defaults to the current state first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (w_go_rise) begin
                    w_next_state = SEND_RESET ? S_RST_ISSUE : S_LOAD;
                end
            end
            S_RST_ISSUE, S_LOAD: w_next_state = S_ISSUE;
            S_ISSUE: begin
                if (CMD_READY) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (CMD_DONE) begin
                    w_next_state = (!CMD_NACK || w_retry_ok) ? S_SETTLE : S_FAIL;
                end
            end
            S_SETTLE: begin
                if (w_settle_done) begin
                    if (r_retry_pend) begin
                        w_next_state = r_is_reset_wr ? S_RST_ISSUE : S_LOAD;
                    end else if (w_last_entry) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            r_go_sync     <= '0;
            r_go_prev     <= 1'b0;
            r_tbl_index   <= '0;
            r_cmd_data    <= '0;
            r_retry_cnt   <= '0;
            r_settle_cnt  <= '0;
            r_is_reset_wr <= 1'b0;
            r_retry_pend  <= 1'b0;
            r_err_index   <= '0;
        end else begin
            r_go_sync <= {r_go_sync[0], GO};
            r_go_prev <= r_go_sync[1];

            if (r_state == S_SETTLE && !w_settle_done) begin
                r_settle_cnt <= r_settle_cnt + 16'd1;
            end else begin
                r_settle_cnt <= '0;
            end

            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (w_go_rise) begin
                        r_err_index   <= '0;
                        r_retry_cnt   <= '0;
                        r_retry_pend  <= 1'b0;
                        r_tbl_index   <= '0;
                        r_is_reset_wr <= SEND_RESET;
                    end
                end
                S_RST_ISSUE: r_cmd_data <= {RESET_ADDR, {DATA_W{1'b0}}};
                S_LOAD:      r_cmd_data <= TBL_ENTRY;
                S_WAIT: begin
                    if (CMD_DONE) begin
                        if (!CMD_NACK) begin
                            r_retry_cnt <= '0;
                        end else if (w_retry_ok) begin
                            r_retry_cnt  <= r_retry_cnt + 4'd1;
                            r_retry_pend <= 1'b1;
                        end else begin
                            // Position counts the reset write as slot 0 when it is sent.
                            r_err_index <= r_is_reset_wr ? '0 : ({1'b0, r_tbl_index} + ERR_OFS);
                            r_tbl_index <= '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (w_settle_done) begin
                        if (r_retry_pend) begin
                            r_retry_pend <= 1'b0;
                        end else if (r_is_reset_wr) begin
                            r_is_reset_wr <= 1'b0;
                        end else if (r_tbl_index == LAST_IDX) begin
                            r_tbl_index <= '0;
                        end else begin
                            r_tbl_index <= r_tbl_index + IDX_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign TBL_INDEX = r_tbl_index;
    assign CMD_DATA  = r_cmd_data;
    assign CMD_VALID = (r_state == S_ISSUE);
    assign BUSY      = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);
    assign END       = (r_state == S_DONE);
    assign ERROR     = (r_state == S_FAIL);
    assign ERR_INDEX = r_err_index;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: scoreboarded random runs on a default instance plus
// a directed handshake-stall run on a single-entry instance without soft reset.
module tb_codec_cfg_sequencer;

    localparam int NREG_A   = 10;
    localparam int SETTLE_A = 16;
    localparam int MAXR_A   = 3;
    localparam int SETTLE_B = 4;

    typedef struct {
        logic [15:0] data;
        bit          nack;
    } txn_t;

    logic MCLK = 1'b0;
    logic RESET;
    always #10 MCLK = ~MCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Instance A: default parameters
    logic        a_go, a_cmd_valid, a_cmd_ready, a_cmd_done, a_cmd_nack;
    logic        a_busy, a_end, a_error;
    logic [3:0]  a_tbl_index;
    logic [15:0] a_tbl_entry, a_cmd_data;
    logic [4:0]  a_err_index;
    logic [15:0] tbl_a [NREG_A];

    assign a_tbl_entry = (a_tbl_index < NREG_A) ? tbl_a[a_tbl_index] : 16'hDEAD;

    codec_cfg_sequencer #(
        .NUM_REGS(NREG_A), .SEND_RESET(1'b1), .SETTLE_CYCLES(SETTLE_A), .MAX_RETRIES(MAXR_A)
    ) u_dut_a (
        .MCLK(MCLK), .RESET(RESET), .GO(a_go),
        .TBL_INDEX(a_tbl_index), .TBL_ENTRY(a_tbl_entry),
        .CMD_VALID(a_cmd_valid), .CMD_READY(a_cmd_ready), .CMD_DATA(a_cmd_data),
        .CMD_DONE(a_cmd_done), .CMD_NACK(a_cmd_nack),
        .BUSY(a_busy), .END(a_end), .ERROR(a_error), .ERR_INDEX(a_err_index)
    );

    // Instance B: one entry, no soft reset
    logic        b_go, b_cmd_valid, b_cmd_ready, b_cmd_done, b_cmd_nack;
    logic        b_busy, b_end, b_error;
    logic [0:0]  b_tbl_index;
    logic [15:0] b_tbl_entry, b_cmd_data, tbl_b;
    logic [1:0]  b_err_index;

    assign b_tbl_entry = tbl_b;

    codec_cfg_sequencer #(
        .NUM_REGS(1), .SEND_RESET(1'b0), .SETTLE_CYCLES(SETTLE_B), .MAX_RETRIES(3)
    ) u_dut_b (
        .MCLK(MCLK), .RESET(RESET), .GO(b_go),
        .TBL_INDEX(b_tbl_index), .TBL_ENTRY(b_tbl_entry),
        .CMD_VALID(b_cmd_valid), .CMD_READY(b_cmd_ready), .CMD_DATA(b_cmd_data),
        .CMD_DONE(b_cmd_done), .CMD_NACK(b_cmd_nack),
        .BUSY(b_busy), .END(b_end), .ERROR(b_error), .ERR_INDEX(b_err_index)
    );

    // Scoreboard: expected writes in order, and the response the master gives each one
    txn_t exp_q[$];
    bit   nack_q[$];

    // I2C master model for instance A
    bit a_rand_ready = 1'b0;
    int pend = 0;
    bit hs_next = 1'b0;

    initial begin
        a_cmd_ready = 1'b0;
        a_cmd_done  = 1'b0;
        a_cmd_nack  = 1'b0;
        forever begin
            @(posedge MCLK);
            #2;
            a_cmd_done = 1'b0;
            a_cmd_nack = 1'b0;
            if (pend == 1) begin
                a_cmd_done = 1'b1;
                a_cmd_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
            end
            if (pend > 0) pend--;
            if (hs_next) pend = $urandom_range(3, 8);
            a_cmd_ready = a_rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            hs_next = a_cmd_valid && a_cmd_ready;
        end
    end

    // Monitor for instance A
    int          cyc = 0;
    int          done_cyc = 0;
    int          hs_a = 0;
    bit          have_done = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = '0;
    txn_t        mon_t;

    always @(negedge MCLK) begin
        cyc++;
        if (RESET) begin
            if (prev_valid && !prev_ready) begin
                check("valid_held", a_cmd_valid, 1);
                check("data_stable", a_cmd_data, prev_data);
            end
            if (a_cmd_valid && !prev_valid && have_done)
                check("settle_gap", (cyc - done_cyc) >= SETTLE_A + 1, 1);
            if (a_cmd_done) begin
                have_done = 1'b1;
                done_cyc  = cyc;
            end
            if (a_cmd_valid && a_cmd_ready) begin
                hs_a++;
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", exp_q.size(), 1);
                end else begin
                    mon_t = exp_q.pop_front();
                    check("cmd_data", a_cmd_data, mon_t.data);
                    nack_q.push_back(mon_t.nack);
                end
            end
        end
        prev_valid = a_cmd_valid;
        prev_ready = a_cmd_ready;
        prev_data  = a_cmd_data;
    end

    int hs_b = 0;
    always @(negedge MCLK) begin
        if (RESET && b_cmd_valid && b_cmd_ready) hs_b++;
    end

    // Reference model: the ordered list of writes a run must produce, one per attempt.
    task automatic plan_a(input int nack_entry, input int nack_times,
                          output bit fails, output int fail_pos);
        fails    = 1'b0;
        fail_pos = 0;
        for (int i = 0; i < NREG_A; i++) tbl_a[i] = 16'($urandom);
        for (int p = 0; p <= NREG_A && !fails; p++) begin
            logic [15:0] d;
            d = (p == 0) ? 16'h1E00 : tbl_a[p-1];
            for (int a = 0; a <= MAXR_A; a++) begin
                bit nk;
                nk = (p - 1 == nack_entry) && (a < nack_times);
                exp_q.push_back('{data: d, nack: nk});
                if (!nk) break;
                if (a == MAXR_A) begin
                    fails    = 1'b1;
                    fail_pos = p;
                end
            end
        end
    endtask

    task automatic pulse_go_a();
        @(posedge MCLK);
        #3 a_go = 1'b1;
        repeat (3) @(posedge MCLK);
        #3 a_go = 1'b0;
    endtask

    task automatic wait_end_a();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge MCLK);
            if (a_end || a_error) begin
                ok = 1'b1;
                break;
            end
        end
        check("seq_finished_in_time", ok, 1);
    endtask

    task automatic check_final_a(input bit fails, input int pos);
        check("end_flag", a_end, !fails);
        check("error_flag", a_error, fails);
        check("busy_after", a_busy, 0);
        if (fails) check("err_index", a_err_index, pos);
        check("tbl_index_rest", a_tbl_index, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic clear_env();
        pend      = 0;
        hs_next   = 1'b0;
        have_done = 1'b0;
        exp_q.delete();
        nack_q.delete();
    endtask

    initial begin
        bit fails;
        int pos;
        int base;
        bit ok;

        RESET = 1'b0;
        a_go = 1'b0;
        b_go = 1'b0;
        b_cmd_ready = 1'b0;
        b_cmd_done  = 1'b0;
        b_cmd_nack  = 1'b0;
        tbl_b = 16'($urandom);
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_valid", a_cmd_valid, 0);
        check("rst_data", a_cmd_data, 0);
        check("rst_index", a_tbl_index, 0);
        check("rst_busy", a_busy, 0);
        check("rst_end", a_end, 0);
        check("rst_error", a_error, 0);
        check("rst_err_index", a_err_index, 0);
        check("rst_b_valid", b_cmd_valid, 0);
        @(posedge MCLK);
        #3 RESET = 1'b1;
        repeat (5) @(posedge MCLK);
        #1 check("idle_busy", a_busy, 0);

        // Clean run with random READY
        a_rand_ready = 1'b1;
        plan_a(-1, 0, fails, pos);
        pulse_go_a();
        wait_end_a();
        check_final_a(fails, pos);

        // Entry 4 NACKed twice, then acknowledged
        plan_a(4, 2, fails, pos);
        pulse_go_a();
        wait_end_a();
        check_final_a(fails, pos);

        // Entry 7 NACKed on every attempt
        plan_a(7, 99, fails, pos);
        check("model_fail_pos", pos, 8);
        pulse_go_a();
        wait_end_a();
        check_final_a(fails, pos);
        repeat (60) @(negedge MCLK);
        check("fail_held", a_error, 1);
        check("fail_valid_low", a_cmd_valid, 0);

        // GO held high with an extra edge while busy: exactly one sequence
        plan_a(-1, 0, fails, pos);
        @(posedge MCLK);
        #3 a_go = 1'b1;
        repeat (40) @(posedge MCLK);
        #3 a_go = 1'b0;
        repeat (2) @(posedge MCLK);
        #3 a_go = 1'b1;
        wait_end_a();
        check_final_a(fails, pos);
        repeat (40) @(negedge MCLK);
        check("held_go_no_restart", a_end, 1);
        check("held_go_busy", a_busy, 0);

        // New edge after END restarts and clears END
        @(posedge MCLK);
        #3 a_go = 1'b0;
        repeat (5) @(posedge MCLK);
        plan_a(-1, 0, fails, pos);
        #3 a_go = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge MCLK);
            if (a_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("restart_busy", ok, 1);
        check("restart_end_cleared", a_end, 0);
        #3 a_go = 1'b0;
        wait_end_a();
        check_final_a(fails, pos);

        // Instance B: READY held low for 20 cycles
        @(posedge MCLK);
        #3 b_go = 1'b1;
        repeat (3) @(posedge MCLK);
        #3 b_go = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge MCLK);
            if (b_cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_valid_rises", ok, 1);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge MCLK);
                if (!b_cmd_valid || b_cmd_data !== tbl_b) bad++;
            end
            check("b_stall_hold_bad_cycles", bad, 0);
        end
        check("b_data", b_cmd_data, tbl_b);
        @(posedge MCLK);
        #2 b_cmd_ready = 1'b1;
        @(posedge MCLK);
        #2 b_cmd_ready = 1'b0;
        @(negedge MCLK);
        check("b_valid_dropped", b_cmd_valid, 0);
        repeat (2) @(posedge MCLK);
        #2 b_cmd_done = 1'b1;
        @(posedge MCLK);
        #2 b_cmd_done = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge MCLK);
            if (b_end || b_error) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_finished_in_time", ok, 1);
        check("b_end", b_end, 1);
        check("b_error", b_error, 0);
        check("b_busy", b_busy, 0);
        check("b_one_txn", hs_b, 1);

        // Reset during WAIT of table entry 5
        base = hs_a;
        plan_a(-1, 0, fails, pos);
        pulse_go_a();
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge MCLK);
            if (hs_a >= base + 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("reached_entry5", ok, 1);
        @(posedge MCLK);
        #5;
        check("entry5_index", a_tbl_index, 5);
        RESET = 1'b0;
        #1;
        check("arst_valid", a_cmd_valid, 0);
        check("arst_data", a_cmd_data, 0);
        check("arst_index", a_tbl_index, 0);
        check("arst_busy", a_busy, 0);
        check("arst_end", a_end, 0);
        check("arst_error", a_error, 0);
        check("arst_err_index", a_err_index, 0);
        clear_env();
        repeat (3) @(posedge MCLK);
        #5 RESET = 1'b1;
        repeat (50) @(negedge MCLK);
        check("post_rst_busy", a_busy, 0);
        check("post_rst_valid", a_cmd_valid, 0);
        check("post_rst_end", a_end, 0);
        check("post_rst_no_cmd", hs_a, base + 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
